// File: rtl/aes128_round_ctrl.sv
// Sequencing controller for an iterative AES-128 round datapath: issues load,
// round-commit and key-schedule strobes, generates Rcon, and hands off results.
module aes128_round_ctrl #(
  parameter int NUM_ROUNDS       = 10,
  parameter int CYCLES_PER_ROUND = 1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             dp_load,
  output logic             key_load,
  output logic             dp_round_en,
  output logic             dp_final,
  output logic [2:0]       dp_sub_idx,
  output logic             key_step,
  output logic [7:0]       rcon,
  output logic [3:0]       round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam logic [2:0] SUB_LAST   = 3'(CYCLES_PER_ROUND - 1);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_HOLD} state_t;

  state_t           state, state_nxt;
  logic [3:0]       round_nxt;
  logic [2:0]       sub_nxt;
  logic [7:0]       rcon_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             commit;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      round      <= 4'd0;
      dp_sub_idx <= 3'd0;
      rcon       <= 8'h01;
      blk_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      round      <= round_nxt;
      dp_sub_idx <= sub_nxt;
      rcon       <= rcon_nxt;
      blk_cnt    <= cnt_nxt;
    end
  end

  assign commit = (state == S_ROUND) && (dp_sub_idx == SUB_LAST);

  // Every return to IDLE rewinds round/sub/rcon so the next block starts clean.
  always_comb begin
    state_nxt = state;
    round_nxt = round;
    sub_nxt   = dp_sub_idx;
    rcon_nxt  = rcon;
    cnt_nxt   = blk_cnt;
    case (state)
      S_IDLE: begin
        if (start && !abort) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (abort) begin
          state_nxt = S_IDLE;
          round_nxt = 4'd0;
          sub_nxt   = 3'd0;
          rcon_nxt  = 8'h01;
        end else begin
          state_nxt = S_ROUND;
          round_nxt = 4'd1;
          sub_nxt   = 3'd0;
          rcon_nxt  = 8'h01;
        end
      end
      S_ROUND: begin
        if (abort) begin
          state_nxt = S_IDLE;
          round_nxt = 4'd0;
          sub_nxt   = 3'd0;
          rcon_nxt  = 8'h01;
        end else if (commit) begin
          if (round == LAST_ROUND) begin
            state_nxt = S_HOLD;
          end else begin
            round_nxt = round + 4'd1;
            sub_nxt   = 3'd0;
            rcon_nxt  = xtime(rcon);
          end
        end else begin
          sub_nxt = dp_sub_idx + 3'd1;
        end
      end
      S_HOLD: begin
        // Result handshake: completes on a cycle with out_valid=1 and
        // out_ready=1; abort in the same cycle discards it uncounted.
        if (abort || out_ready) begin
          state_nxt = S_IDLE;
          round_nxt = 4'd0;
          sub_nxt   = 3'd0;
          rcon_nxt  = 8'h01;
          if (!abort) cnt_nxt = blk_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    busy        = 1'b0;
    dp_load     = 1'b0;
    key_load    = 1'b0;
    dp_round_en = 1'b0;
    dp_final    = 1'b0;
    key_step    = 1'b0;
    out_valid   = 1'b0;
    case (state)
      S_IDLE: ready = 1'b1;
      S_LOAD: begin
        busy     = 1'b1;
        dp_load  = !abort;
        key_load = !abort;
      end
      S_ROUND: begin
        busy        = 1'b1;
        dp_round_en = commit && !abort;
        key_step    = commit && !abort;
        dp_final    = commit && !abort && (round == LAST_ROUND);
      end
      S_HOLD: out_valid = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: doc/aes128_round_ctrl.md
Name: aes128_round_ctrl

Overview:
- Sequencing controller for the iterative AES-128 round datapath built from the saed90 flop library.
- Accepts a block-start request, drives the initial-AddRoundKey load, then drives NUM_ROUNDS round commits, which may be multi-cycle when the S-box is shared.
- Generates Rcon and the round-key step strobes for the key expander, and presents completion through a valid/ready handshake.
- Contains no datapath; it only issues strobes and selects.

Parameters:
- NUM_ROUNDS, 10: number of rounds after the initial AddRoundKey; the last round is the final round, which skips MixColumns.
- CYCLES_PER_ROUND, 1: cycles per round (1 = full-width datapath; 4 = 32-bit column-serial datapath); legal range 1..8.
- CNT_W, 16: width of the completed-block counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to process a block; accepted only when ready=1.
- abort  in  1  synchronous abort of an in-flight block.
- ready  out  1  controller idle; start is accepted this cycle.
- busy  out  1  high in LOAD and ROUND.
- dp_load  out  1  datapath loads plaintext XOR key (round 0).
- key_load  out  1  key expander loads the cipher key.
- dp_round_en  out  1  datapath commits the current round.
- dp_final  out  1  qualifies dp_round_en as the final round (no MixColumns).
- dp_sub_idx  out  3  sub-cycle (column) index within the round.
- key_step  out  1  key expander advances one round key.
- rcon  out  8  round constant for the current round.
- round  out  4  current round number, 0..NUM_ROUNDS.
- out_valid  out  1  ciphertext in the datapath is valid.
- out_ready  in  1  consumer accepts the ciphertext.
- blk_cnt  out  CNT_W  count of completed output handshakes.

Behaviour:
- States: IDLE, LOAD, ROUND, HOLD. All outputs are decoded from registered state; datapath and key strobes are additionally gated by ~abort.
- Reset (rst=1 at an edge):
  - state=IDLE, round=0, dp_sub_idx=0, rcon=8'h01, blk_cnt=0.
  - After the edge: ready=1; busy, all strobes, dp_final and out_valid are 0.
  - rst overrides every other input, including mid-operation.
- IDLE:
  - ready=1.
  - start=1 & abort=0 -> LOAD.
  - start=1 & abort=1 -> remain in IDLE.
- LOAD: one cycle; dp_load=1, key_load=1, round=0. Next state ROUND with round=1, sub=0, rcon=01.
- ROUND:
  - dp_sub_idx counts 0..CYCLES_PER_ROUND-1.
  - On the last sub-cycle: dp_round_en=1 and key_step=1, both in the same cycle. rcon holds the value for the current round during the commit.
  - dp_final=1 on the commit of round NUM_ROUNDS only.
  - After a non-final commit: round+1, sub=0, rcon=xtime(rcon), where xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - After the final commit -> HOLD.
  - Rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
- HOLD:
  - out_valid=1; round, rcon and outputs held stable.
  - out_ready=1 -> IDLE next cycle and blk_cnt+1; blk_cnt wraps modulo 2^CNT_W.
  - start is ignored in HOLD; ready=0.
- Latency: start accepted at edge T -> out_valid first high in cycle T+2+NUM_ROUNDS*CYCLES_PER_ROUND. Default parameters give T+12.
- Abort:
  - In LOAD, ROUND or HOLD: the current-cycle strobes are suppressed; next state IDLE with round=0, sub=0, rcon=01.
  - blk_cnt is unchanged.
  - Abort in HOLD drops the result; no handshake is counted, even if out_ready=1 in the same cycle.
  - Abort in IDLE has no effect.
- Invariants:
  - dp_load, dp_round_en, out_valid and ready are mutually exclusive.
  - key_step implies dp_round_en.
  - round never exceeds NUM_ROUNDS.

Test Plan:
1. Defaults: reset, start pulse at T -> LOAD strobes at T+1; commits at T+2..T+11 with rcon 01,02,04,08,10,20,40,80,1b,36; dp_final only at T+11; out_valid at T+12; with out_ready=1, ready=1 at T+13 and blk_cnt=1.
2. Backpressure: hold out_ready=0 for 5 cycles in HOLD while pulsing start -> out_valid stays 1, ready stays 0, no new LOAD; then out_ready=1 -> IDLE next cycle, blk_cnt increments by exactly 1.
3. CYCLES_PER_ROUND=4: dp_sub_idx cycles 0,1,2,3 each round; dp_round_en and key_step only at sub=3; out_valid at T+42.
4. abort asserted on sub-cycle 0 of round 5 -> no strobes in that cycle; IDLE next cycle with rcon=01, round=0, blk_cnt unchanged; a following start completes with normal latency and the correct Rcon sequence.
5. rst asserted during round 7 -> next cycle IDLE, ready=1, blk_cnt=0, all strobes 0.
6. start=1 and abort=1 together in IDLE -> remain in IDLE, dp_load never asserted; start alone on the next cycle -> LOAD.
